// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit simplified MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, retires instructions, and parks on the halt word.
module multicycle_controller #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      instruction,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic             pc_source,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;
    logic       is_rtype;
    logic       is_addi;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_defined;
    logic       is_halt;
    logic [3:0] rtype_alu;

    assign opcode     = instruction[15:12];
    assign is_rtype   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                        (opcode == OP_OR)  || (opcode == OP_SLT);
    assign is_addi    = (opcode == OP_ADDI);
    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_bne     = (opcode == OP_BNE);
    assign is_defined = is_rtype || is_addi || is_lw || is_sw || is_beq || is_bne;
    assign is_halt    = (instruction == HALT_WORD);

    // ALU function for the R-type group
    always_comb begin
        rtype_alu = ALU_ADD;
        case (opcode)
            OP_SUB:  rtype_alu = ALU_SUB;
            OP_AND:  rtype_alu = ALU_AND;
            OP_OR:   rtype_alu = ALU_OR;
            OP_SLT:  rtype_alu = ALU_SLT;
            default: rtype_alu = ALU_ADD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (is_halt)          state_next = S_HALT;
                else if (!is_defined) state_next = S_FETCH;
                else                  state_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_beq || is_bne)    state_next = S_FETCH;
                else if (is_lw || is_sw) state_next = S_MEM;
                else                     state_next = S_WB;
            end
            S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing is written while the machine is held
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        pc_source   = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (is_beq || is_bne) begin
                    alu_src_b   = 2'b00;
                    alu_control = ALU_SUB;
                    pc_source   = 1'b1;
                    pc_write    = is_beq ? zero : ~zero;
                end else if (is_rtype) begin
                    alu_src_b   = 2'b00;
                    alu_control = rtype_alu;
                end else begin
                    alu_src_b   = 2'b10;
                end
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    // Retire on every return to FETCH from an instruction-processing state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if ((state != S_FETCH) && (state != S_HALT) && (state_next == S_FETCH)) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and randomized instruction streams against a per-phase reference model.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_multicycle_controller;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;
    localparam int PH_HALT   = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
    logic alu_src_a, pc_source, halted;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic [15:0] retired;

    logic pc_write4, ir_write4, iord4, mem_read4, mem_write4, reg_write4, reg_dst4, mem_to_reg4;
    logic alu_src_a4, pc_source4, halted4;
    logic [1:0] alu_src_b4;
    logic [3:0] alu_control4;
    logic [3:0] retired4;

    logic [16:0] obs_big, obs_small;
    int n_cmp = 0;
    int n_err = 0;
    int retired_model = 0;

    multicycle_controller #(.CNT_W(16), .HALT_WORD(16'hFFFF)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_source(pc_source), .halted(halted), .retired(retired)
    );

    multicycle_controller #(.CNT_W(4), .HALT_WORD(16'hFFFF)) dut4 (
        .clock(clock), .reset(reset), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write4), .ir_write(ir_write4), .iord(iord4), .mem_read(mem_read4),
        .mem_write(mem_write4), .reg_write(reg_write4), .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_control(alu_control4),
        .pc_source(pc_source4), .halted(halted4), .retired(retired4)
    );

    assign obs_big   = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                        mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source, halted};
    assign obs_small = {pc_write4, ir_write4, iord4, mem_read4, mem_write4, reg_write4, reg_dst4,
                        mem_to_reg4, alu_src_a4, alu_src_b4, alu_control4, pc_source4, halted4};

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected control word for one cycle, straight from the per-phase rules
    function automatic logic [16:0] model_outs(input int phase, input logic [15:0] ins,
                                               input logic rdy, input logic z);
        logic pcw, irw, io, mr, mw, rw, rd, m2r, sa, pcs, h;
        logic [1:0] sb;
        logic [3:0] ac;
        logic [3:0] op;
        op = ins[15:12];
        {pcw, irw, io, mr, mw, rw, rd, m2r, sa, pcs, h} = 11'b0;
        sb = 2'b00;
        ac = 4'b0010;
        case (phase)
            PH_FETCH: begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
            PH_DECODE: sb = 2'b11;
            PH_EXEC: begin
                sa = 1'b1;
                case (op)
                    4'h0: ac = 4'b0010;
                    4'h2: ac = 4'b0110;
                    4'h3: ac = 4'b0000;
                    4'h4: ac = 4'b0001;
                    4'h5: ac = 4'b0111;
                    4'h8, 4'h9: begin ac = 4'b0110; pcs = 1'b1; pcw = (op == 4'h8) ? z : !z; end
                    default: sb = 2'b10;
                endcase
            end
            PH_MEM: begin io = 1'b1; mr = (op == 4'h6); mw = (op == 4'h7); end
            PH_WB: begin rw = 1'b1; rd = (op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5}); m2r = (op == 4'h6); end
            PH_HALT: h = 1'b1;
            default: ;
        endcase
        return {pcw, irw, io, mr, mw, rw, rd, m2r, sa, sb, ac, pcs, h};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [16:0] exp_o);
        cmp({tag, " outs"}, 32'(obs_big), 32'(exp_o));
        cmp({tag, " outs4"}, 32'(obs_small), 32'(exp_o));
        cmp({tag, " retired"}, 32'(retired), 32'(retired_model % 65536));
        cmp({tag, " retired4"}, 32'(retired4), 32'(retired_model % 16));
    endtask

    task automatic check_strobes_off(input string tag);
        cmp({tag, " strobes"}, 32'({pc_write, ir_write, mem_write, reg_write, halted,
                                    pc_write4, ir_write4, mem_write4, reg_write4, halted4}), 32'd0);
        cmp({tag, " retired"}, 32'({retired, retired4}), 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic release_reset(input string tag);
        mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all({tag, " release"}, model_outs(PH_FETCH, 16'h0, 1'b0, 1'b0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'b1;
        retired_model = 0;
        #1;
        check_strobes_off(tag);
        release_reset(tag);
    endtask

    // Drive one instruction through the machine, checking every cycle; abort_at >= 0 resets in MEM
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic z,
                             input string tag, input int abort_at);
        logic [3:0] op;
        op = ins[15:12];
        for (int i = 0; i <= fw; i++) begin
            step();
            instruction = 16'($urandom);
            mem_ready = (i == fw);
            zero = 1'($urandom);
            #1;
            check_all({tag, " fetch"}, model_outs(PH_FETCH, ins, mem_ready, zero));
        end
        step();
        instruction = ins;
        mem_ready = 1'($urandom);
        zero = 1'($urandom);
        #1;
        check_all({tag, " decode"}, model_outs(PH_DECODE, ins, mem_ready, zero));
        if (op > 4'h9) begin
            retired_model++;
            return;
        end
        step();
        mem_ready = 1'($urandom);
        zero = z;
        #1;
        check_all({tag, " exec"}, model_outs(PH_EXEC, ins, mem_ready, zero));
        if (op == 4'h8 || op == 4'h9) begin
            retired_model++;
            return;
        end
        if (op == 4'h6 || op == 4'h7) begin
            for (int i = 0; i <= mw; i++) begin
                step();
                mem_ready = (i == mw);
                zero = 1'($urandom);
                #1;
                check_all({tag, " mem"}, model_outs(PH_MEM, ins, mem_ready, zero));
                if (i == abort_at) begin
                    #2;
                    reset = 1'b1;
                    retired_model = 0;
                    #1;
                    check_strobes_off({tag, " abort"});
                    return;
                end
            end
            if (op == 4'h7) begin
                retired_model++;
                return;
            end
        end
        step();
        mem_ready = 1'($urandom);
        #1;
        check_all({tag, " wb"}, model_outs(PH_WB, ins, mem_ready, zero));
        retired_model++;
    endtask

    initial begin
        logic [15:0] r;
        #3;
        check_strobes_off("por");
        release_reset("por");

        run_instr(16'h0040, 0, 0, 1'b0, "add", -1);
        run_instr(16'h6105, 0, 3, 1'b0, "lw_wait", -1);
        run_instr(16'h8003, 0, 0, 1'b1, "beq_z1", -1);
        run_instr(16'h8003, 0, 0, 1'b0, "beq_z0", -1);
        run_instr(16'h9003, 0, 0, 1'b1, "bne_z1", -1);
        run_instr(16'h9003, 0, 0, 1'b0, "bne_z0", -1);
        run_instr(16'h1234, 1, 0, 1'b0, "addi", -1);
        run_instr(16'h2180, 0, 0, 1'b0, "sub", -1);
        run_instr(16'h3240, 0, 0, 1'b0, "and", -1);
        run_instr(16'h4300, 0, 0, 1'b0, "or", -1);
        run_instr(16'h51C0, 0, 0, 1'b0, "slt", -1);
        run_instr(16'h7102, 2, 1, 1'b0, "sw", -1);
        run_instr(16'hC000, 0, 0, 1'b0, "nop_c", -1);
        run_instr(16'hF000, 0, 0, 1'b0, "nop_f", -1);
        run_instr(16'hFFFE, 0, 0, 1'b0, "nop_fffe", -1);

        for (int k = 0; k < 60; k++) begin
            r = 16'($urandom);
            if (r == 16'hFFFF) r = 16'hFFFE;
            run_instr(r, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), "rand", -1);
        end

        run_instr(16'h7102, 0, 3, 1'b0, "sw_rst", 1);
        release_reset("sw_rst");

        for (int k = 0; k < 16; k++) run_instr(16'hA000, 0, 0, 1'b0, "nop_wrap", -1);
        step();
        mem_ready = 1'b0;
        #1;
        check_all("wrap_end", model_outs(PH_FETCH, 16'h0, 1'b0, 1'b0));

        do_reset("pre_halt");
        run_instr(16'h0040, 0, 0, 1'b0, "add_h1", -1);
        run_instr(16'h0080, 0, 0, 1'b0, "add_h2", -1);
        step();
        instruction = 16'($urandom);
        mem_ready = 1'b1;
        #1;
        check_all("halt fetch", model_outs(PH_FETCH, 16'h0, 1'b1, 1'b0));
        step();
        instruction = 16'hFFFF;
        mem_ready = 1'($urandom);
        #1;
        check_all("halt decode", model_outs(PH_DECODE, 16'hFFFF, mem_ready, 1'b0));
        for (int k = 0; k < 21; k++) begin
            step();
            instruction = 16'($urandom);
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            #1;
            check_all("halt park", model_outs(PH_HALT, instruction, mem_ready, zero));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
